apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of APB requesters (2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles before forced error (1..65535).
REQ-005 SHALL use one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 s_psel  input  NUM_REQ  per-requester select.
REQ-009 s_penable  input  NUM_REQ  per-requester enable.
REQ-010 s_pwrite  input  NUM_REQ  per-requester write flag.
REQ-011 s_paddr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-012 s_pwdata  input  NUM_REQ*DATA_WIDTH  packed write data.
REQ-013 s_prdata  output  NUM_REQ*DATA_WIDTH  packed read data.
REQ-014 s_pready  output  NUM_REQ  per-requester ready.
REQ-015 s_pslverr  output  NUM_REQ  per-requester error.
REQ-016 m_psel, m_penable, m_pwrite  output  1 each  shared APB master controls.
REQ-017 m_paddr  output  ADDR_WIDTH; m_pwdata  output  DATA_WIDTH.
REQ-018 m_prdata  input  DATA_WIDTH; m_pready  input  1; m_pslverr  input  1.
REQ-019 busy  output  1  high whenever FSM not IDLE.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS; all master outputs registered.
REQ-021 IDLE: requester i is pending when s_psel[i]=1; with any pending, latch grant, pwrite, paddr, pwdata of winner; go SETUP next cycle.
REQ-022 Winner: round-robin, first pending at or after priority pointer ptr, searching upward with wrap-around NUM_REQ-1 -> 0.
REQ-023 SETUP: m_psel=1, m_penable=0, latched address/data/pwrite driven; unconditionally go ACCESS.
REQ-024 ACCESS: m_psel=1, m_penable=1; clear timeout counter on ACCESS entry, increment each ACCESS cycle without m_pready.
REQ-025 ACCESS with m_pready=1: in that same cycle s_pready[grant]=1, s_pslverr[grant]=m_pslverr, s_prdata slice grant=m_prdata (combinational pass-through); next state IDLE.
REQ-026 ACCESS with counter reaching TIMEOUT and m_pready=0: s_pready[grant]=1, s_pslverr[grant]=1, s_prdata slice=0 that cycle; next state IDLE with m_psel=0.
REQ-027 On completion (normal or timeout) ptr SHALL become (grant+1) mod NUM_REQ.
REQ-028 Non-granted requesters: s_pready=0, s_pslverr=0, s_prdata slice=0 at all times.
REQ-029 Minimum latency: requester psel in cycle N -> m_psel in N+1, m_penable in N+2, s_pready earliest in N+2.
REQ-030 Back-to-back: IDLE lasts exactly one cycle between transactions (m_psel low one cycle).
REQ-031 Granted requester dropping s_psel during SETUP/ACCESS: transaction completes on master side; s_pready pulse still issued, no abort.
REQ-032 Requests arriving in SETUP/ACCESS are not sampled until next IDLE.
REQ-033 Latched fields SHALL NOT change during SETUP/ACCESS even if requester inputs change.
REQ-034 s_penable is not used for arbitration; only s_psel qualifies a request.

Reset
REQ-035 On rst=1: state IDLE, ptr=0, grant=0, counter=0, m_psel=m_penable=m_pwrite=0, m_paddr=m_pwdata=0, busy=0, all s_pready/s_pslverr/s_prdata=0, asynchronously.
REQ-036 rst asserted mid-transaction SHALL abandon it with no s_pready pulse; first arbitration after release uses ptr=0.

Verification
REQ-037 Single read: s_psel[0]=1, paddr=0x004, m_pready=1 in first ACCESS, m_prdata=0xDEADBEEF -> m_psel cycle 1, m_penable cycle 2, s_pready[0]=1 with 0xDEADBEEF in cycle 2.
REQ-038 Simultaneous: s_psel=2'b11 after reset -> req0 served first, then req1, IDLE gap of one cycle; next simultaneous pair served req0 first again (ptr wrapped to 0).
REQ-039 Wait states: m_pready low 3 ACCESS cycles then high with m_pslverr=1 -> s_pready/s_pslverr on 4th ACCESS cycle only to grant.
REQ-040 Timeout: TIMEOUT=4, m_pready held 0 -> s_pready[grant]=1, s_pslverr=1, s_prdata=0 on 4th ACCESS cycle; m_psel low next cycle.
REQ-041 Reset mid-ACCESS -> all outputs 0 immediately, no s_pready; next request from req1 alone granted normally.
REQ-042 Input change: req0 changes s_paddr 0x010->0x020 during SETUP -> m_paddr stays 0x010 through ACCESS.

Source files
------------

// File: rtl/apb_arbiter.sv
// Round-robin arbiter: NUM_REQ APB requesters share one APB master port, with a per-transfer ACCESS timeout.
// Latency: s_psel to m_psel is 1 cycle, s_pready 2 cycles at the earliest; the bus is held until m_pready or timeout.
module apb_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             s_psel,
    input  logic [NUM_REQ-1:0]             s_penable,
    input  logic [NUM_REQ-1:0]             s_pwrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_paddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_pwdata,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  s_prdata,
    output logic [NUM_REQ-1:0]             s_pready,
    output logic [NUM_REQ-1:0]             s_pslverr,
    output logic                           m_psel,
    output logic                           m_penable,
    output logic                           m_pwrite,
    output logic [ADDR_WIDTH-1:0]          m_paddr,
    output logic [DATA_WIDTH-1:0]          m_pwdata,
    input  logic [DATA_WIDTH-1:0]          m_prdata,
    input  logic                           m_pready,
    input  logic                           m_pslverr,
    output logic                           busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [GW-1:0]         r_ptr;
    logic [GW-1:0]         r_grant;
    logic [15:0]           r_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic [NUM_REQ-1:0]    w_rot;
    logic                  w_any;
    logic [GW-1:0]         w_off;
    logic [GW:0]           w_sum;
    logic [GW-1:0]         w_win;
    logic [GW:0]           w_inc;
    logic [GW-1:0]         w_ptr_nxt;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [16:0]           w_cnt_inc;
    logic                  w_done_ok;
    logic                  w_tmo;
    logic                  w_done;
    logic                  w_unused;

    // s_penable never qualifies a request
    assign w_unused = ^s_penable;

    // Rotate so bit 0 is the requester at the priority pointer; the lowest set bit wins
    assign w_rot = NUM_REQ'({s_psel, s_psel} >> r_ptr);

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = GW'(k);
            end
        end
    end

    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win = (w_sum >= (GW+1)'(NUM_REQ)) ? GW'(w_sum - (GW+1)'(NUM_REQ)) : GW'(w_sum);

    assign w_inc     = {1'b0, r_grant} + (GW+1)'(1);
    assign w_ptr_nxt = (w_inc >= (GW+1)'(NUM_REQ)) ? GW'(w_inc - (GW+1)'(NUM_REQ)) : GW'(w_inc);

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == GW'(i)) begin
                w_sel_write = s_pwrite[i];
                w_sel_addr  = s_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = s_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Counter holds the number of unready ACCESS cycles already spent; this cycle would make it one more
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_done_ok = (r_state == ST_ACCESS) && m_pready;
    assign w_tmo     = (r_state == ST_ACCESS) && !m_pready && (w_cnt_inc == 17'(TIMEOUT));
    assign w_done    = w_done_ok || w_tmo;

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_done && (r_grant == GW'(i))) begin
                s_pready[i]  = 1'b1;
                s_pslverr[i] = w_tmo ? 1'b1 : m_pslverr;
                if (w_done_ok) begin
                    s_prdata[i*DATA_WIDTH +: DATA_WIDTH] = m_prdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state   <= ST_SETUP;
                        r_grant   <= w_win;
                        r_pwrite  <= w_sel_write;
                        r_paddr   <= w_sel_addr;
                        r_pwdata  <= w_sel_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ptr     <= w_ptr_nxt;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign m_psel    = r_psel;
    assign m_penable = r_penable;
    assign m_pwrite  = r_pwrite;
    assign m_paddr   = r_paddr;
    assign m_pwdata  = r_pwdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: randomized rounds of requests against a round-robin reference model and slave model.
module tb_apb_arbiter;

    localparam int N   = 3;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct {
        int          id;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        int            waits;
        logic          err;
        logic [DW-1:0] rdata;
    } plan_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    s_psel, s_penable, s_pwrite;
    logic [N*AW-1:0] s_paddr;
    logic [N*DW-1:0] s_pwdata, s_prdata;
    logic [N-1:0]    s_pready, s_pslverr;
    logic            m_psel, m_penable, m_pwrite;
    logic [AW-1:0]   m_paddr;
    logic [DW-1:0]   m_pwdata, m_prdata;
    logic            m_pready, m_pslverr, busy;

    int n_tot;
    int n_bad;
    int mptr;
    exp_t  exp_q[$];
    plan_t plan_q[$];

    logic [AW-1:0] r_addr[N];
    logic [DW-1:0] r_wdata[N];
    logic          r_wr[N];
    logic          r_err[N];
    logic [DW-1:0] r_rd[N];
    int            r_wait[N];

    apb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_m_psel"}, m_psel, 0);
        chk({tag, "_m_penable"}, m_penable, 0);
        chk({tag, "_m_pwrite"}, m_pwrite, 0);
        chk({tag, "_m_paddr"}, m_paddr, 0);
        chk({tag, "_m_pwdata"}, m_pwdata, 0);
        chk({tag, "_s_pready"}, s_pready, 0);
        chk({tag, "_s_pslverr"}, s_pslverr, 0);
        chk({tag, "_s_prdata"}, s_prdata, 0);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            r_addr[i]  = AW'($urandom);
            r_wdata[i] = $urandom;
            r_wr[i]    = 1'($urandom);
            r_err[i]   = 1'($urandom);
            r_rd[i]    = $urandom;
            r_wait[i]  = $urandom_range(0, 5);
        end
    endtask

    // Model: pending requesters are served in cyclic order starting at the pointer;
    // each completion moves the pointer just past the served requester.
    task automatic run_round(input logic [N-1:0] mask);
        int order[$];
        int lat[$];
        int cyc, idx, due, cur;
        for (int k = 0; k < N; k++) begin
            int  id;
            bit  tmo;
            id = (mptr + k) % N;
            if (mask[id]) begin
                tmo = (r_wait[id] >= TMO);
                order.push_back(id);
                lat.push_back(tmo ? TMO : r_wait[id] + 1);
                exp_q.push_back('{id, r_addr[id], r_wdata[id], r_wr[id],
                                  tmo ? 1'b1 : r_err[id], tmo ? 32'h0 : r_rd[id]});
                plan_q.push_back('{r_wait[id], r_err[id], r_rd[id]});
            end
        end
        if (order.size() > 0) mptr = (order[order.size()-1] + 1) % N;

        @(negedge clk); #1;
        for (int i = 0; i < N; i++) begin
            s_penable[i] = 1'($urandom);
            if (mask[i]) begin
                s_psel[i]              = 1'b1;
                s_pwrite[i]            = r_wr[i];
                s_paddr[i*AW +: AW]    = r_addr[i];
                s_pwdata[i*DW +: DW]   = r_wdata[i];
            end
        end

        cyc = 0;
        idx = 0;
        due = (order.size() > 0) ? 1 + lat[0] : 0;
        while (idx < order.size() && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
            cur = order[idx];
            if (m_psel && !m_penable) begin
                s_paddr[cur*AW +: AW]  = s_paddr[cur*AW +: AW] ^ AW'($urandom_range(1, 4095));
                s_pwdata[cur*DW +: DW] = s_pwdata[cur*DW +: DW] ^ ($urandom | 32'h1);
                s_pwrite[cur]          = ~s_pwrite[cur];
                if ($urandom_range(0, 3) == 0) s_psel[cur] = 1'b0;
            end
            if (s_pready != '0) begin
                chk("latency", cyc, due);
                s_psel[cur] = 1'b0;
                idx++;
                if (idx < order.size()) due = cyc + 2 + lat[idx];
            end
        end
        if (idx < order.size()) begin
            n_tot++;
            n_bad++;
            $display("FAIL round_timeout: served %0d of %0d", idx, order.size());
            s_psel = '0;
            exp_q.delete();
            plan_q.delete();
        end
    endtask

    // Slave model: replays the planned wait count, error and read data for each ACCESS phase
    initial begin
        plan_t cp;
        bit    act;
        int    cnt;
        act = 0;
        cnt = 0;
        cp = '{0, 1'b0, 32'h0};
        m_pready = 1'b0;
        m_pslverr = 1'b0;
        m_prdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                act = 0;
                plan_q.delete();
                m_pready = 1'b0;
                continue;
            end
            if (m_psel && m_penable) begin
                if (!act) begin
                    act = 1;
                    cnt = 0;
                    if (plan_q.size() == 0) begin
                        n_tot++;
                        n_bad++;
                        $display("FAIL slave_plan: unplanned ACCESS at t=%0t", $time);
                        cp = '{100, 1'b0, 32'h0};
                    end else begin
                        cp = plan_q.pop_front();
                    end
                end
                if (cnt == cp.waits) begin
                    m_pready  = 1'b1;
                    m_pslverr = cp.err;
                    m_prdata  = cp.rdata;
                end else begin
                    m_pready  = 1'b0;
                    m_pslverr = 1'($urandom);
                    m_prdata  = $urandom;
                end
                cnt++;
            end else begin
                act = 0;
                m_pready  = 1'($urandom);
                m_pslverr = 1'($urandom);
                m_prdata  = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on every s_pready and checks the response and the bus gap
    initial begin
        bit            gap;
        exp_t          e;
        logic [N*DW-1:0] v;
        gap = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap = 0;
                continue;
            end
            chk("busy_vs_psel", busy, m_psel);
            if (gap) begin
                chk("idle_gap", m_psel, 0);
                gap = 0;
            end
            if (s_pready != '0) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    n_bad++;
                    $display("FAIL unexpected_pready: got %0h want none", s_pready);
                end else begin
                    e = exp_q.pop_front();
                    v = '0;
                    v[e.id*DW +: DW] = e.rdata;
                    chk("grant_pready", s_pready, N'(1) << e.id);
                    chk("pslverr", s_pslverr, N'(e.err) << e.id);
                    chk("prdata", s_prdata, v);
                    chk("m_paddr", m_paddr, e.addr);
                    chk("m_pwdata", m_pwdata, e.wdata);
                    chk("m_pwrite", m_pwrite, e.wr);
                end
                gap = 1;
            end else begin
                chk("idle_slverr", s_pslverr, 0);
                chk("idle_prdata", s_prdata, 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit");
        $display("test done: total=%0d bad=%0d", n_tot, n_bad + 1);
        $fatal(1);
    end

    initial begin
        n_tot     = 0;
        n_bad     = 0;
        mptr      = 0;
        rst       = 1'b1;
        s_psel    = '0;
        s_penable = '0;
        s_pwrite  = '0;
        s_paddr   = '0;
        s_pwdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // single read with immediate ready
        rand_fields();
        r_addr[0] = 12'h004; r_wr[0] = 1'b0; r_wait[0] = 0; r_err[0] = 1'b0; r_rd[0] = 32'hDEADBEEF;
        run_round(3'b001);

        // simultaneous pairs
        rand_fields();
        r_wait[0] = 0; r_wait[1] = 0;
        run_round(3'b011);
        rand_fields();
        run_round(3'b011);

        // three wait states then ready with error
        rand_fields();
        r_wait[2] = 3; r_err[2] = 1'b1;
        run_round(3'b100);

        // slave never ready: forced error after TMO ACCESS cycles
        rand_fields();
        r_wait[0] = 7;
        run_round(3'b001);

        // latched address must survive requester changes in SETUP
        rand_fields();
        r_addr[0] = 12'h010; r_wait[0] = 1;
        run_round(3'b001);

        // reset in the middle of ACCESS
        @(negedge clk); #1;
        s_psel[0] = 1'b1;
        s_paddr[0 +: AW] = 12'h100;
        plan_q.push_back('{10, 1'b0, 32'h0});
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_access", {m_psel, m_penable}, 2'b11);
        #1;
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        s_psel = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        rand_fields();
        run_round(3'b010);
        rand_fields();
        run_round(3'b111);

        for (int r = 0; r < 60; r++) begin
            rand_fields();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_round(N'($urandom_range(1, 7)));
        end

        repeat (3) @(negedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
